fsm_path_driver: RTL and testbench

FSM_PATH_DRIVER -- requirements
Module: fsm_path_driver

---
 rtl/fsm_path_driver.sv | 112 +++++++++++
 tb/tb_fsm_path_driver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fsm_path_driver.sv
// Drives a serial bit stream that walks a downstream 5-state FSM along a shortest path
// to a requested state, tracking that FSM with an internal model.
module fsm_path_driver (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [2:0] req_target,
  output logic       req_ready,
  output logic       a,
  output logic       a_valid,
  output logic [2:0] cur_state,
  output logic       done,
  output logic       err,
  output logic [1:0] steps
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} ctrl_t;

  ctrl_t      ctrl;
  logic [2:0] target;
  logic [2:0] model_nxt;

  // Downstream FSM transition function over output codes {0,2,3,4,5}.
  function automatic logic [2:0] model_next(input logic [2:0] s, input logic bit_in);
    case (s)
      3'd0:    model_next = bit_in ? 3'd4 : 3'd3;
      3'd3:    model_next = bit_in ? 3'd5 : 3'd2;
      3'd4:    model_next = bit_in ? 3'd3 : 3'd0;
      3'd2:    model_next = 3'd4;
      3'd5:    model_next = bit_in ? 3'd2 : 3'd0;
      default: model_next = 3'd0;
    endcase
  endfunction

  // First bit of a shortest path from s to t; ties resolve to 0.
  function automatic logic plan_bit(input logic [2:0] s, input logic [2:0] t);
    plan_bit = 1'b0;
    case (t)
      3'd0:    plan_bit = (s == 3'd3);
      3'd3:    plan_bit = (s == 3'd4);
      3'd5:    plan_bit = (s == 3'd3) || (s == 3'd4);
      3'd2:    plan_bit = (s == 3'd5) || (s == 3'd4);
      3'd4:    plan_bit = (s == 3'd0);
      default: plan_bit = 1'b0;
    endcase
  endfunction

  function automatic logic target_invalid(input logic [2:0] t);
    target_invalid = (t == 3'd1) || (t == 3'd6) || (t == 3'd7);
  endfunction

  assign model_nxt = model_next(cur_state, a);

  // NOTE: every register, including the captured target, is cleared by the async
  // reset so an aborted transaction leaves no stale state behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl      <= IDLE;
      cur_state <= 3'd0;
      target    <= 3'd0;
      a         <= 1'b0;
      a_valid   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      steps     <= 2'd0;
      req_ready <= 1'b1;
    end else begin
      case (ctrl)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (req_valid && req_ready) begin
            target    <= req_target;
            steps     <= 2'd0;
            req_ready <= 1'b0;
            if (target_invalid(req_target)) begin
              ctrl <= RESP;
              err  <= 1'b1;
            end else if (req_target == cur_state) begin
              ctrl <= RESP;
              done <= 1'b1;
            end else begin
              ctrl    <= DRIVE;
              a_valid <= 1'b1;
              a       <= plan_bit(cur_state, req_target);
            end
          end
        end
        DRIVE: begin
          cur_state <= model_nxt;
          steps     <= steps + 2'd1;
          if (model_nxt == target) begin
            ctrl    <= RESP;
            done    <= 1'b1;
            a_valid <= 1'b0;
            a       <= 1'b0;
          end else begin
            a <= plan_bit(model_nxt, target);
          end
        end
        RESP: begin
          done      <= 1'b0;
          err       <= 1'b0;
          req_ready <= 1'b1;
          ctrl      <= IDLE;
        end
        default: ctrl <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_path_driver.sv
// Directed bench for fsm_path_driver with a reference downstream FSM clocked by a_valid.
module tb_fsm_path_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [2:0] req_target;
  logic       req_ready;
  logic       a;
  logic       a_valid;
  logic [2:0] cur_state;
  logic       done;
  logic       err;
  logic [1:0] steps;

  int checks = 0;
  int errors = 0;

  logic [2:0] ref_state;

  fsm_path_driver dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_target (req_target),
    .req_ready  (req_ready),
    .a          (a),
    .a_valid    (a_valid),
    .cur_state  (cur_state),
    .done       (done),
    .err        (err),
    .steps      (steps)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ref_next(input logic [2:0] s, input logic b);
    case (s)
      3'd0:    ref_next = b ? 3'd4 : 3'd3;
      3'd3:    ref_next = b ? 3'd5 : 3'd2;
      3'd4:    ref_next = b ? 3'd3 : 3'd0;
      3'd2:    ref_next = 3'd4;
      3'd5:    ref_next = b ? 3'd2 : 3'd0;
      default: ref_next = 3'd7;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset)       ref_state <= 3'd0;
    else if (a_valid) ref_state <= ref_next(ref_state, a);
  end

  // Reference FSM tracking and output-exclusivity checks on every falling edge.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      checks++;
      if (cur_state !== ref_state) begin
        errors++;
        $display("FAIL ref_track cur_state=%0d ref=%0d", cur_state, ref_state);
      end
      checks++;
      if ((done && err) || (!a_valid && a)) begin
        errors++;
        $display("FAIL exclusive done=%b err=%b a=%b a_valid=%b", done, err, a, a_valid);
      end
    end
  end

  // One full transaction: bits[i] is the i-th expected bit, sts[3*i+:3] the state after it.
  task automatic run_req(input string name, input logic [2:0] tgt, input int n,
                         input logic [2:0] bits, input logic [8:0] sts,
                         input logic exp_done, input logic exp_err);
    logic [2:0] start_state;
    @(negedge clk);
    start_state = cur_state;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready got=%b want=1", name, req_ready);
    end
    req_valid  = 1'b1;
    req_target = tgt;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_target = 3'd1;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (a_valid !== 1'b1 || a !== bits[i] || done !== 1'b0) begin
        errors++;
        $display("FAIL %s_bit%0d a_valid=%b a=%b done=%b want a_valid=1 a=%b done=0",
                 name, i, a_valid, a, done, bits[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (cur_state !== sts[3*i +: 3]) begin
        errors++;
        $display("FAIL %s_state%0d got=%0d want=%0d", name, i, cur_state, sts[3*i +: 3]);
      end
    end
    checks++;
    if (done !== exp_done || err !== exp_err || a_valid !== 1'b0 ||
        steps !== 2'(n) || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_resp done=%b err=%b a_valid=%b steps=%0d ready=%b want done=%b err=%b a_valid=0 steps=%0d ready=0",
               name, done, err, a_valid, steps, req_ready, exp_done, exp_err, n);
    end
    if (n == 0) begin
      checks++;
      if (cur_state !== start_state) begin
        errors++;
        $display("FAIL %s_unchanged got=%0d want=%0d", name, cur_state, start_state);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || err !== 1'b0 || req_ready !== 1'b1 || steps !== 2'(n)) begin
      errors++;
      $display("FAIL %s_idle done=%b err=%b ready=%b steps=%0d want 0 0 1 %0d",
               name, done, err, req_ready, steps, n);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_target = 3'd0;
    #12;
    checks++;
    if (cur_state !== 3'd0 || a !== 1'b0 || a_valid !== 1'b0 || done !== 1'b0 ||
        err !== 1'b0 || steps !== 2'd0) begin
      errors++;
      $display("FAIL reset_vals cur=%0d a=%b av=%b done=%b err=%b steps=%0d want all 0",
               cur_state, a, a_valid, done, err, steps);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%b want=1", req_ready);
    end
  endtask

  task automatic test_paths();
    run_req("t0to5", 3'd5, 2, 3'b010, {3'd0, 3'd5, 3'd3}, 1'b1, 1'b0);
    run_req("t5to4", 3'd4, 2, 3'b010, {3'd0, 3'd4, 3'd0}, 1'b1, 1'b0);
    run_req("t4to2", 3'd2, 2, 3'b001, {3'd0, 3'd2, 3'd3}, 1'b1, 1'b0);
    run_req("t2to4", 3'd4, 1, 3'b000, {3'd0, 3'd0, 3'd4}, 1'b1, 1'b0);
    run_req("t4to2b", 3'd2, 2, 3'b001, {3'd0, 3'd2, 3'd3}, 1'b1, 1'b0);
    run_req("t2to0", 3'd0, 2, 3'b000, {3'd0, 3'd0, 3'd4}, 1'b1, 1'b0);
  endtask

  task automatic test_same_and_invalid();
    run_req("same", 3'd0, 0, 3'b000, 9'd0, 1'b1, 1'b0);
    run_req("inv6", 3'd6, 0, 3'b000, 9'd0, 1'b0, 1'b1);
    run_req("inv1", 3'd1, 0, 3'b000, 9'd0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_in_drive();
    logic seen_done;
    run_req("t0to2", 3'd2, 2, 3'b000, {3'd0, 3'd2, 3'd3}, 1'b1, 1'b0);
    @(negedge clk);
    req_valid  = 1'b1;
    req_target = 3'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (a_valid !== 1'b1 || a !== 1'b0) begin
      errors++;
      $display("FAIL abort_bit0 a_valid=%b a=%b want 1 0", a_valid, a);
    end
    @(posedge clk); #1;
    checks++;
    if (a_valid !== 1'b1 || a !== 1'b1 || cur_state !== 3'd4) begin
      errors++;
      $display("FAIL abort_bit1 a_valid=%b a=%b cur=%0d want 1 1 4", a_valid, a, cur_state);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (cur_state !== 3'd0 || a_valid !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        steps !== 2'd0) begin
      errors++;
      $display("FAIL abort_reset cur=%0d av=%b done=%b err=%b steps=%0d want 0 0 0 0 0",
               cur_state, a_valid, done, err, steps);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    seen_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || err) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0 || req_ready !== 1'b1 || cur_state !== 3'd0) begin
      errors++;
      $display("FAIL abort_after pulse=%b ready=%b cur=%0d want 0 1 0",
               seen_done, req_ready, cur_state);
    end
    run_req("post0to4", 3'd4, 1, 3'b001, {3'd0, 3'd0, 3'd4}, 1'b1, 1'b0);
    run_req("t4to3", 3'd3, 1, 3'b001, {3'd0, 3'd0, 3'd3}, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_paths();
    test_same_and_invalid();
    test_reset_in_drive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
